// File: rtl/stack_ctrl_pkg.sv
// Shared definitions for the stack controller: geometry constants and FSM state encoding.
package stack_ctrl_pkg;

  localparam int DEPTH_C = 8;
  localparam int AW_C    = 3;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2,
    ERR     = 2'd3
  } state_e;

endpackage

// File: rtl/stack_ctrl.sv
// Stack pointer/occupancy controller: gates push/pop strobes to an external stack memory,
// tracks occupancy and raises sticky overflow/underflow flags that park the FSM in ERR.
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_C,
  parameter int AW    = AW_C
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_req,
  input  logic          pop_req,
  input  logic          clr_err,
  output logic          pushenbl,
  output logic          popenbl,
  output logic [AW-1:0] tos,
  output logic          stack_full,
  output logic          stack_empty,
  output logic [AW:0]   count,
  output logic          pop_valid,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] TOS_MAX  = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] tos_q, tos_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          pop_valid_q;
  logic          active;
  logic          push_ok;
  logic          pop_ok;

  function automatic state_e stateFor(input logic [AW:0] c);
    if (c == '0)
      return EMPTY;
    else if (c == CNT_FULL)
      return FULL;
    else
      return PARTIAL;
  endfunction

  // Strobes are suppressed in reset, in ERR and during a clear cycle; pop beats push.
  assign active  = !rst && !clr_err && (state_q != ERR);
  assign pop_ok  = active && pop_req && (state_q != EMPTY);
  assign push_ok = active && push_req && !pop_req && (state_q != FULL);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      if (state_q == ERR)
        state_d = stateFor(count_q);
    end else if (state_q != ERR) begin
      if (pop_req && (state_q == EMPTY)) begin
        underflow_d = 1'b1;
        state_d     = ERR;
      end else if (push_req && !pop_req && (state_q == FULL)) begin
        overflow_d = 1'b1;
        state_d    = ERR;
      end else begin
        if (pop_ok)
          count_d = count_q - CNT_ONE;
        else if (push_ok)
          count_d = count_q + CNT_ONE;
        state_d = stateFor(count_d);
      end
    end
    // When full the top entry sits at DEPTH-1, so the address saturates there.
    tos_d = (count_d == CNT_FULL) ? TOS_MAX : count_d[AW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      count_q     <= '0;
      tos_q       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      pop_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      tos_q       <= tos_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      pop_valid_q <= pop_ok;
    end
  end

  assign pushenbl    = push_ok;
  assign popenbl     = pop_ok;
  assign tos         = tos_q;
  assign count       = count_q;
  assign stack_full  = (count_q == CNT_FULL);
  assign stack_empty = (count_q == '0);
  assign pop_valid   = pop_valid_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Scoreboard bench for stack_ctrl: a queue-based stack model predicts strobes, flags and
// popped data; a negedge monitor compares the controller and a bench-side stack memory.
module tb_stack_ctrl;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          push_req, pop_req, clr_err;
  logic          pushenbl, popenbl;
  logic [AW-1:0] tos;
  logic          stack_full, stack_empty;
  logic [AW:0]   count;
  logic          pop_valid;
  logic          overflow, underflow;
  logic [7:0]    wdata;
  logic [7:0]    mem [DEPTH];
  logic [7:0]    popdataout;

  typedef struct {
    int pe, po, cnt, tosv, full, empty, ovf, udf, pv;
  } exp_t;

  exp_t expQ[$];
  int   dataQ[$];
  int   mStk[$];
  int   mOvf, mUdf, mErr, mLastPop;
  int   checks = 0;
  int   errors = 0;

  stack_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .push_req(push_req), .pop_req(pop_req), .clr_err(clr_err),
    .pushenbl(pushenbl), .popenbl(popenbl), .tos(tos), .stack_full(stack_full),
    .stack_empty(stack_empty), .count(count), .pop_valid(pop_valid),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Stack memory as wired at integration: write at tos, read at tos (full) or tos-1.
  always @(posedge clk) begin
    if (pushenbl)
      mem[tos] <= wdata;
    if (popenbl)
      popdataout <= mem[stack_full ? tos : tos - 3'd1];
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mStk.delete();
    expQ.delete();
    dataQ.delete();
    mOvf = 0; mUdf = 0; mErr = 0; mLastPop = 0;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    push_req = 1'b0; pop_req = 1'b0; clr_err = 1'b0; wdata = '0;
    modelReset();
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  // Drives one cycle of requests and queues what the controller must show in that cycle.
  task automatic applyStimulus(input bit p, input bit q, input bit c, input logic [7:0] d);
    exp_t e;
    @(posedge clk); #2;
    push_req = p; pop_req = q; clr_err = c; wdata = d;
    e.cnt   = mStk.size();
    e.tosv  = (mStk.size() == DEPTH) ? DEPTH - 1 : mStk.size();
    e.full  = int'(mStk.size() == DEPTH);
    e.empty = int'(mStk.size() == 0);
    e.ovf   = mOvf;
    e.udf   = mUdf;
    e.pv    = mLastPop;
    e.pe    = 0;
    e.po    = 0;
    if (c) begin
      mOvf = 0; mUdf = 0; mErr = 0;
    end else if (mErr == 0) begin
      if (q) begin
        if (mStk.size() == 0) begin
          mUdf = 1; mErr = 1;
        end else begin
          e.po = 1;
          dataQ.push_back(mStk.pop_back());
        end
      end else if (p) begin
        if (mStk.size() == DEPTH) begin
          mOvf = 1; mErr = 1;
        end else begin
          e.pe = 1;
          mStk.push_back(int'(d));
        end
      end
    end
    mLastPop = e.po;
    expQ.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("pushenbl", int'(pushenbl), e.pe);
      checkOutput("popenbl", int'(popenbl), e.po);
      checkOutput("count", int'(count), e.cnt);
      checkOutput("tos", int'(tos), e.tosv);
      checkOutput("stack_full", int'(stack_full), e.full);
      checkOutput("stack_empty", int'(stack_empty), e.empty);
      checkOutput("overflow", int'(overflow), e.ovf);
      checkOutput("underflow", int'(underflow), e.udf);
      checkOutput("pop_valid", int'(pop_valid), e.pv);
    end
    if (!rst && pop_valid) begin
      if (dataQ.size() == 0)
        checkOutput("pop_unexpected", 1, 0);
      else
        checkOutput("popdataout", int'(popdataout), dataQ.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    push_req = 1'b1; pop_req = 1'b0; clr_err = 1'b0; wdata = '0;
    modelReset();
    #3;
    checkOutput("rst_pushenbl", int'(pushenbl), 0);
    checkOutput("rst_count", int'(count), 0);
    checkOutput("rst_tos", int'(tos), 0);
    checkOutput("rst_empty", int'(stack_empty), 1);
    checkOutput("rst_full", int'(stack_full), 0);
    checkOutput("rst_pop_valid", int'(pop_valid), 0);
    applyReset();

    for (int i = 1; i <= DEPTH; i++)
      applyStimulus(1, 0, 0, 8'(i));
    applyStimulus(1, 0, 0, 8'd99);
    applyStimulus(1, 0, 0, 8'd98);
    applyStimulus(0, 1, 0, 8'd0);
    applyStimulus(0, 0, 1, 8'd0);
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(0, 1, 0, 8'd0);
    applyStimulus(0, 0, 0, 8'd0);
    applyStimulus(0, 1, 0, 8'd0);
    applyStimulus(1, 0, 0, 8'd77);
    applyStimulus(0, 0, 1, 8'd0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 0, 0, 8'(20 + i));
    applyStimulus(1, 1, 0, 8'd55);
    applyStimulus(1, 1, 1, 8'd56);
    applyStimulus(0, 1, 0, 8'd0);
    applyStimulus(0, 1, 0, 8'd0);
    applyStimulus(1, 1, 0, 8'd57);
    applyStimulus(0, 0, 1, 8'd0);

    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      applyStimulus(r < 50, (r >= 40) && (r < 88), r >= 95, 8'($urandom));
    end
    applyStimulus(0, 0, 1, 8'd0);
    applyStimulus(0, 0, 0, 8'd0);
    applyStimulus(0, 0, 0, 8'd0);

    applyReset();
    for (int i = 0; i < 6; i++)
      applyStimulus(1, 0, 0, 8'(40 + i));
    applyStimulus(0, 1, 0, 8'd0);
    @(posedge clk); #2;
    pop_req = 1'b1;
    #1;
    checkOutput("prereset_pop_valid", int'(pop_valid), 1);
    checkOutput("prereset_count", int'(count), 5);
    rst = 1'b1;
    #1;
    checkOutput("midpop_pop_valid", int'(pop_valid), 0);
    checkOutput("midpop_count", int'(count), 0);
    checkOutput("midpop_tos", int'(tos), 0);
    checkOutput("midpop_popenbl", int'(popenbl), 0);
    applyReset();
    for (int i = 0; i < 40; i++)
      applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, 0, 8'($urandom));
    applyStimulus(0, 0, 0, 8'd0);
    applyStimulus(0, 0, 0, 8'd0);
    @(negedge clk);
    #1;
    checkOutput("scoreboard_drained", expQ.size() + dataQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
